mmio_uart_tx: RTL and testbench

- Memory-mapped serial transmit port, downstream of the ARMv4 core's data-memory bus (`MemWrite`, `DataAdr`, `WriteData`).
- Core stores bytes to a data register; the block queues them in a FIFO and serializes them as 8N1 frames on `tx`.
- Exposes a status word the core can read back.
- Gives the processor a visible output channel in simulation and on the board.

---
 rtl/mmio_uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: the core stores bytes to DATA, they are
// queued in a small FIFO and shifted out LSB-first on tx. STATUS reads back
// {overflow, full, empty, busy}; CTRL bit 0 clears the sticky overflow flag.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;

  // Serializer state
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             tx_n;

  // Combinational strobes
  logic full_c;
  logic empty_c;
  logic push_req_c;
  logic push_c;
  logic pop_c;
  logic drop_c;
  logic clr_c;
  logic rd_c;
  logic last_c;
  logic busy_n_c;
  logic unused_ok_c;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign push_req_c = MemWrite && (DataAdr == DATA_ADDR);
  // A full FIFO still accepts a byte when the serializer pops on the same edge.
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign drop_c     = push_req_c && !push_c;
  assign clr_c      = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
  assign rd_c       = !MemWrite && (DataAdr == STATUS_ADDR);
  assign last_c     = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
  assign busy_n_c   = (state_n != S_IDLE) || (count_n != '0);
  assign unused_ok_c = ^WriteData[31:8];

  // Next FIFO occupancy from this edge's push/pop
  always_comb begin
    count_n = count;
    case ({push_c, pop_c})
      2'b10:   count_n = CNT_W'(count + 1'b1);
      2'b01:   count_n = CNT_W'(count - 1'b1);
      default: count_n = count;
    endcase
  end

  // Serializer next-state and next-output logic
  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    pop_c   = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n  = 1'b1;
        cyc_n = '0;
        bit_n = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (last_c) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
          tx_n    = shift[0];
        end else begin
          cyc_n = CYC_W'(cyc_cnt + 1'b1);
        end
      end
      S_DATA: begin
        if (last_c) begin
          cyc_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = 3'(bit_idx + 1'b1);
            tx_n  = shift[1];
          end
        end else begin
          cyc_n = CYC_W'(cyc_cnt + 1'b1);
        end
      end
      S_STOP: begin
        if (last_c) begin
          cyc_n   = '0;
          state_n = S_IDLE;
          tx_n    = 1'b1;
        end else begin
          cyc_n = CYC_W'(cyc_cnt + 1'b1);
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Serializer state register; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n_c;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_c)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      count <= count_n;
    end
  end

  // FIFO payload storage, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem[wr_ptr] <= WriteData[7:0];
  end

  // Sticky overflow and registered STATUS readback
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      ReadData <= '0;
    end else begin
      if (drop_c)     overflow <= 1'b1;
      else if (clr_c) overflow <= 1'b0;
      ReadData <= rd_c ? {28'b0, overflow, full_c, empty_c, busy} : 32'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset, single frame timing, FIFO overflow,
// status/clear, address decode and reset mid-frame.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx;
  logic        busy;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .DEPTH(8),
    .BASE_ADDR(32'h0000_0400),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes frames into a byte queue with their start cycle
  int         cyc = 0;
  bit         mon_on = 1'b0;
  int         mon_cnt = 0;
  int         mon_st = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] q_bytes[$];
  int         q_start[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
        mon_st  = cyc;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % CPB) == 0 && mon_cnt <= 8 * CPB)
        mon_byte[3'(mon_cnt / CPB - 1)] = tx;
      if (mon_cnt == 9 * CPB) begin
        check("stop_bit", 32'(tx), 32'd1);
        q_bytes.push_back(mon_byte);
        q_start.push_back(mon_st);
        mon_on = 1'b0;
      end
    end
  end

  // Bus helpers, called right after a falling edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
    MemWrite = 1'b0;
    DataAdr  = a;
    @(negedge clk);
    r       = ReadData;
    DataAdr = 32'h0;
  endtask

  logic [31:0] rd_val;
  logic [9:0]  frm;

  initial begin
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    rst       = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles with bus activity, including a DATA store
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin MemWrite = 1'b1; DataAdr = 32'h400; WriteData = 32'h77; end
        1:       begin MemWrite = 1'b0; DataAdr = 32'h408; WriteData = 32'h0;  end
        default: begin MemWrite = 1'b1; DataAdr = 32'h400; WriteData = 32'h3C; end
      endcase
      @(negedge clk);
      check("rst_tx",       32'(tx),       32'd1);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_readdata", ReadData,      32'd0);
    end
    MemWrite = 1'b0;
    DataAdr  = 32'h0;
    rst      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_tx", 32'(tx), 32'd1);
    end
    check("post_rst_busy",   32'(busy), 32'd0);
    check("post_rst_frames", 32'(q_bytes.size()), 32'd0);

    // Single byte 0xA5: start bit two edges after the store
    bus_wr(32'h400, 32'h1234_56A5);
    check("lat_e0_tx",   32'(tx),   32'd1);
    check("lat_e0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_tx", 32'(tx), 32'd0);
    frm = {1'b1, 8'hA5, 1'b0};
    for (int k = 1; k < 10 * CPB; k++) begin
      @(negedge clk);
      check("frame_a5_tx", 32'(tx), 32'(frm[4'(k / CPB)]));
    end
    check("busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("idle_tx",   32'(tx),   32'd1);
    check("a5_count",  32'(q_bytes.size()), 32'd1);
    if (q_bytes.size() > 0) check("a5_byte", 32'(q_bytes[0]), 32'h0000_00A5);
    q_bytes.delete();
    q_start.delete();
    repeat (3) @(negedge clk);

    // Ten back-to-back stores into an 8-deep FIFO: 0x0A is dropped
    for (int i = 1; i <= 10; i++) bus_wr(32'h400, 32'(i));
    check("ovf_set",  32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy),     32'd1);
    repeat (60) @(negedge clk);
    bus_rd(32'h408, rd_val);
    check("status_mid", rd_val, 32'h0000_0009);
    @(negedge clk);
    check("readdata_idle", ReadData, 32'h0);
    bus_wr(32'h404, 32'h1);
    check("ovf_clear", 32'(overflow), 32'd0);
    repeat (400) @(negedge clk);
    check("ovf_frames", 32'(q_bytes.size()), 32'd9);
    for (int i = 0; i < q_bytes.size(); i++) begin
      check("ovf_byte", 32'(q_bytes[i]), 32'(i + 1));
      if (i > 0) check("frame_gap", 32'(q_start[i] - q_start[i-1]), 32'(10 * CPB + 1));
    end
    check("drain_busy", 32'(busy), 32'd0);
    bus_rd(32'h408, rd_val);
    check("status_drained", rd_val, 32'h0000_0002);
    q_bytes.delete();
    q_start.delete();

    // Near-miss addresses must not push
    bus_wr(32'h40C, 32'h55);
    bus_wr(32'h300, 32'h66);
    bus_wr(32'h401, 32'h77);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("decode_tx", 32'(tx), 32'd1);
    end
    check("decode_busy",   32'(busy), 32'd0);
    check("decode_frames", 32'(q_bytes.size()), 32'd0);
    bus_rd(32'h408, rd_val);
    check("decode_status", rd_val, 32'h0000_0002);

    // Reset during data bit 3 of 0x5A with two bytes still queued
    bus_wr(32'h400, 32'h5A);
    bus_wr(32'h400, 32'h11);
    bus_wr(32'h400, 32'h22);
    repeat (12) @(negedge clk);
    check("bit2_5a", 32'(tx), 32'd0);
    repeat (4) @(negedge clk);
    check("bit3_5a",   32'(tx),   32'd1);
    check("bit3_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx",   32'(tx),   32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("after_midrst_tx", 32'(tx), 32'd1);
    end
    check("after_midrst_busy",   32'(busy), 32'd0);
    check("after_midrst_frames", 32'(q_bytes.size()), 32'd0);
    bus_rd(32'h408, rd_val);
    check("after_midrst_status", rd_val, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
